// File: rtl/rx_audio_pkt_buf.sv
// Double-banked RX sample buffer: serialises per-channel I/Q sets into one bank while the
// other bank is read out as a ticks-stamped packet of DW-bit words.
module rx_audio_pkt_buf #(
  parameter int N_CH      = 4,
  parameter int DW        = 16,
  parameter int MAX_SAMPS = 512
) (
  input  logic                   adc_clk,
  input  logic                   reset_A,
  input  logic [9:0]             nrx_samps,
  input  logic [N_CH-1:0]        rx_en,
  input  logic                   rx_avail,
  input  logic [N_CH*2*DW-1:0]   rxn_din,
  input  logic [47:0]            ticks,
  input  logic                   rd_start,
  input  logic                   rd_en,
  output logic                   busy,
  output logic                   srq,
  output logic [DW-1:0]          dout,
  output logic                   dout_valid,
  output logic [15:0]            buf_ctr,
  output logic                   ovfl,
  input  logic                   ovfl_clr
);

  localparam int NW    = 2 * N_CH;
  localparam int DEPTH = NW * MAX_SAMPS;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int RW    = AW + 2;
  localparam int SW    = $clog2(NW);
  localparam int NSW   = $clog2(MAX_SAMPS) + 1;

  logic [DW-1:0]      r_mem   [0:1][0:DEPTH-1];
  logic [47:0]        r_ticks [0:1];
  logic [PW-1:0]      r_len   [0:1];

  logic               r_busy, r_done, r_doomed, r_wr_bank, r_last;
  logic [NW-1:0]      r_pend;
  logic [NW*DW-1:0]   r_set;
  logic [N_CH-1:0]    r_en;
  logic [NSW-1:0]     r_ns, r_set_cnt;
  logic [PW-1:0]      r_wr_ptr;
  logic [1:0]         r_full;
  logic               r_rd_active, r_rd_bank;
  logic [RW-1:0]      r_rd_idx;
  logic [DW-1:0]      r_dout;
  logic               r_dout_valid, r_ovfl, r_srq;
  logic [15:0]        r_buf_ctr;

  logic [31:0]        w_nrx32;
  logic [NSW-1:0]     w_ns;
  logic               w_start, w_tgt_bank, w_accept, w_drop, w_set_last, w_ns_hit;
  logic [N_CH-1:0]    w_en_eff;
  logic [1:0]         w_occ;
  logic [SW-1:0]      w_sel;
  logic [NW-1:0]      w_pend_nxt, w_pend_init;
  logic               w_rd_sel, w_rd_go, w_pop, w_srq_nxt;
  logic [RW-1:0]      w_rd_last_idx;
  logic [AW-1:0]      w_rd_addr;
  logic [DW-1:0]      w_rd_word;

  assign w_nrx32 = {22'd0, nrx_samps};
  assign w_ns    = (w_nrx32 == 32'd0 || w_nrx32 > 32'(MAX_SAMPS)) ? NSW'(MAX_SAMPS) : NSW'(w_nrx32);

  // A bank is occupied while it holds an unread buffer or is being read.
  assign w_occ[0] = r_full[0] | (r_rd_active & ~r_rd_bank);
  assign w_occ[1] = r_full[1] | (r_rd_active &  r_rd_bank);

  // In the completion cycle a new buffer may already start, so it targets the post-toggle bank.
  assign w_tgt_bank = (r_done && !r_doomed) ? ~r_wr_bank : r_wr_bank;
  assign w_start    = (r_set_cnt == {NSW{1'b0}});
  assign w_en_eff   = w_start ? rx_en : r_en;
  assign w_accept   = rx_avail && !r_busy && (w_en_eff != {N_CH{1'b0}});
  assign w_drop     = rx_avail && r_busy;

  // Pick the lowest pending word and build the pending mask for a newly accepted set.
  always_comb begin
    w_sel       = {SW{1'b0}};
    w_pend_init = {NW{1'b0}};
    for (int k = NW - 1; k >= 0; k--) begin
      w_sel = r_pend[k] ? SW'(k) : w_sel;
    end
    for (int n = 0; n < N_CH; n++) begin
      w_pend_init[2*n]   = w_en_eff[n];
      w_pend_init[2*n+1] = w_en_eff[n];
    end
  end

  assign w_pend_nxt = r_pend & ~(NW'(1) << w_sel);
  assign w_set_last = r_busy && (w_pend_nxt == {NW{1'b0}});
  assign w_ns_hit   = ((r_set_cnt + NSW'(1)) == r_ns);

  assign w_rd_sel      = (r_full == 2'b11) ? ~r_last : r_full[1];
  assign w_rd_go       = rd_start && r_srq && !r_rd_active && (r_full != 2'b00);
  assign w_pop         = rd_en && r_rd_active;
  assign w_rd_last_idx = RW'(r_len[r_rd_bank]) + RW'(2);
  assign w_rd_addr     = AW'(r_rd_idx - RW'(3));
  assign w_srq_nxt     = (r_full[0] && !(r_rd_active && !r_rd_bank)) ||
                         (r_full[1] && !(r_rd_active &&  r_rd_bank));

  // Read word mux: three ticks words lead the packet, then sample words.
  always_comb begin
    case (r_rd_idx)
      RW'(0):  w_rd_word = r_ticks[r_rd_bank][15:0];
      RW'(1):  w_rd_word = r_ticks[r_rd_bank][31:16];
      RW'(2):  w_rd_word = r_ticks[r_rd_bank][47:32];
      default: w_rd_word = r_mem[r_rd_bank][w_rd_addr];
    endcase
  end

  // Sample and timestamp storage; a buffer aimed at an occupied bank never writes it.
  always_ff @(posedge adc_clk) begin
    if (r_busy && !r_doomed) r_mem[r_wr_bank][r_wr_ptr[AW-1:0]] <= r_set[w_sel*DW +: DW];
    if (w_accept && w_start && !w_occ[w_tgt_bank]) r_ticks[w_tgt_bank] <= ticks;
  end

  // Control state: serialiser, buffer completion, read-out and status flags.
  always_ff @(posedge adc_clk or posedge reset_A) begin
    if (reset_A) begin
      r_busy <= 1'b0;  r_pend <= {NW{1'b0}};  r_set <= {NW*DW{1'b0}};
      r_en <= {N_CH{1'b0}};  r_ns <= {NSW{1'b0}};  r_set_cnt <= {NSW{1'b0}};
      r_done <= 1'b0;  r_doomed <= 1'b0;  r_wr_bank <= 1'b0;  r_last <= 1'b0;
      r_wr_ptr <= {PW{1'b0}};  r_full <= 2'b00;
      r_len[0] <= {PW{1'b0}};  r_len[1] <= {PW{1'b0}};
      r_rd_active <= 1'b0;  r_rd_bank <= 1'b0;  r_rd_idx <= {RW{1'b0}};
      r_dout <= {DW{1'b0}};  r_dout_valid <= 1'b0;  r_ovfl <= 1'b0;
      r_srq <= 1'b0;  r_buf_ctr <= 16'd0;
    end else begin
      if (w_accept) begin
        r_busy <= 1'b1;
        r_pend <= w_pend_init;
        r_set  <= rxn_din;
        if (w_start) begin
          r_en     <= rx_en;
          r_ns     <= w_ns;
          r_doomed <= w_occ[w_tgt_bank];
        end
      end else if (r_busy) begin
        r_busy <= (w_pend_nxt != {NW{1'b0}});
        r_pend <= w_pend_nxt;
      end

      if (r_busy) r_wr_ptr <= r_wr_ptr + PW'(1);

      r_done <= 1'b0;
      if (w_set_last) begin
        if (w_ns_hit) begin
          r_set_cnt <= {NSW{1'b0}};
          r_done    <= 1'b1;
        end else begin
          r_set_cnt <= r_set_cnt + NSW'(1);
        end
      end

      if (r_done) begin
        r_wr_ptr <= {PW{1'b0}};
        if (!r_doomed) begin
          r_full[r_wr_bank] <= 1'b1;
          r_len[r_wr_bank]  <= r_wr_ptr;
          r_buf_ctr         <= r_buf_ctr + 16'd1;
          r_wr_bank         <= ~r_wr_bank;
          r_last            <= r_wr_bank;
        end
      end

      // A same-cycle set beats the clear.
      if (w_drop || (r_done && r_doomed)) r_ovfl <= 1'b1;
      else if (ovfl_clr)                  r_ovfl <= 1'b0;

      if (w_rd_go) begin
        r_rd_active <= 1'b1;
        r_rd_bank   <= w_rd_sel;
        r_rd_idx    <= {RW{1'b0}};
      end

      if (w_pop) begin
        r_dout       <= w_rd_word;
        r_dout_valid <= 1'b1;
        if (r_rd_idx == w_rd_last_idx) begin
          r_rd_active       <= 1'b0;
          r_full[r_rd_bank] <= 1'b0;
        end else begin
          r_rd_idx <= r_rd_idx + RW'(1);
        end
      end else begin
        r_dout_valid <= 1'b0;
      end

      r_srq <= w_srq_nxt;
    end
  end

  assign busy       = r_busy;
  assign srq        = r_srq;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign buf_ctr    = r_buf_ctr;
  assign ovfl       = r_ovfl;

endmodule

// File: tb/tb_rx_audio_pkt_buf.sv
// Scoreboard bench for rx_audio_pkt_buf: expected read words are queued as reads are issued
// and a negedge monitor compares them against dout whenever dout_valid is high.
module tb_rx_audio_pkt_buf;

  logic         adc_clk = 1'b0;
  logic         reset_A = 1'b1;
  logic [9:0]   nrx_samps = 10'd0;
  logic [3:0]   rx_en = 4'd0;
  logic         rx_avail = 1'b0;
  logic [127:0] rxn_din = 128'd0;
  logic [47:0]  ticks = 48'd0;
  logic         rd_start = 1'b0;
  logic         rd_en = 1'b0;
  logic         ovfl_clr = 1'b0;
  logic         busy, srq, dout_valid, ovfl;
  logic [15:0]  dout, buf_ctr;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [15:0]  exp_q [$];
  logic [15:0]  mon_exp;

  rx_audio_pkt_buf #(.N_CH(4), .DW(16), .MAX_SAMPS(8)) dut (
    .adc_clk(adc_clk), .reset_A(reset_A), .nrx_samps(nrx_samps), .rx_en(rx_en),
    .rx_avail(rx_avail), .rxn_din(rxn_din), .ticks(ticks), .rd_start(rd_start),
    .rd_en(rd_en), .busy(busy), .srq(srq), .dout(dout), .dout_valid(dout_valid),
    .buf_ctr(buf_ctr), .ovfl(ovfl), .ovfl_clr(ovfl_clr)
  );

  always #5 adc_clk = ~adc_clk;

  // Monitor: every valid output word is checked against the head of the queue.
  always @(negedge adc_clk) begin
    if (!reset_A && dout_valid === 1'b1) begin
      n_chk = n_chk + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_extra: got %h expected no word", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_word: got %h expected %h", dout, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  // Channel n carries I = {p,n,0} and Q = {p,n,1}.
  function automatic logic [127:0] mk(input logic [7:0] p);
    logic [127:0] v;
    v = 128'd0;
    for (int n = 0; n < 4; n++) begin
      v[n*32 +: 16]      = {p, 4'(n), 4'h0};
      v[n*32 + 16 +: 16] = {p, 4'(n), 4'h1};
    end
    return v;
  endfunction

  task automatic push_ticks(input logic [47:0] t);
    exp_q.push_back(t[15:0]);
    exp_q.push_back(t[31:16]);
    exp_q.push_back(t[47:32]);
  endtask

  task automatic push_ch01(input logic [7:0] p);
    exp_q.push_back({p, 8'h00});
    exp_q.push_back({p, 8'h01});
    exp_q.push_back({p, 8'h10});
    exp_q.push_back({p, 8'h11});
  endtask

  task automatic send_set(input logic [7:0] p);
    rxn_din  = mk(p);
    rx_avail = 1'b1;
    tick();
    rx_avail = 1'b0;
  endtask

  task automatic busy_len(input int exp);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt = cnt + 1;
      tick();
    end
    chk("busy_len", 48'(cnt), 48'(exp));
  endtask

  task automatic fill2(input logic [47:0] t, input logic [7:0] p1, input logic [7:0] p2);
    ticks = t;
    send_set(p1);
    ticks = ~t;
    busy_len(4);
    repeat (4) tick();
    send_set(p2);
    busy_len(4);
    repeat (3) tick();
  endtask

  task automatic read_n(input int n);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
    repeat (3) tick();
    chk("sb_empty", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic do_reset();
    reset_A = 1'b1;
    rx_avail = 1'b0; rd_start = 1'b0; rd_en = 1'b0; ovfl_clr = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset_A = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);   chk("rst_srq", srq, 0);
    chk("rst_dout", dout, 0);   chk("rst_dvalid", dout_valid, 0);
    chk("rst_bufctr", buf_ctr, 0); chk("rst_ovfl", ovfl, 0);
    reset_A = 1'b0;
    tick();

    // Basic two-set buffer, channels 0 and 1.
    rx_en = 4'b0011; nrx_samps = 10'd2;
    fill2(48'h1234_5678_9ABC, 8'hA0, 8'hB0);
    chk("b1_bufctr", buf_ctr, 1);
    chk("b1_srq", srq, 1);
    push_ticks(48'h1234_5678_9ABC); push_ch01(8'hA0); push_ch01(8'hB0);
    read_n(11);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rd_hold_valid", dout_valid, 0);
    chk("rd_hold_dout", dout, 16'hB011);
    chk("srq_after_rd", srq, 0);

    // Drop while busy, clear, then set-wins-over-clear.
    do_reset();
    rx_en = 4'b0011; nrx_samps = 10'd2; ticks = 48'h0000_1111_2222;
    send_set(8'h91);
    ticks = 48'hDEAD_DEAD_DEAD;
    rxn_din = mk(8'h92); rx_avail = 1'b1; tick(); rx_avail = 1'b0;
    chk("ovfl_set", ovfl, 1);
    ovfl_clr = 1'b1; tick(); ovfl_clr = 1'b0;
    chk("ovfl_clr", ovfl, 0);
    busy_len(2);
    repeat (4) tick();
    send_set(8'h93);
    rxn_din = mk(8'h94); rx_avail = 1'b1; ovfl_clr = 1'b1; tick();
    rx_avail = 1'b0; ovfl_clr = 1'b0;
    chk("ovfl_set_wins", ovfl, 1);
    busy_len(3);
    repeat (3) tick();
    chk("drop_bufctr", buf_ctr, 1);
    push_ticks(48'h0000_1111_2222); push_ch01(8'h91); push_ch01(8'h93);
    read_n(11);

    // Three buffers without reading: third discarded, reads come out oldest first.
    do_reset();
    rx_en = 4'b0011; nrx_samps = 10'd2;
    fill2(48'h0001_0002_0003, 8'h71, 8'h72);
    fill2(48'h0004_0005_0006, 8'h73, 8'h74);
    fill2(48'h0007_0008_0009, 8'h75, 8'h76);
    chk("ovr_bufctr", buf_ctr, 2);
    chk("ovr_ovfl", ovfl, 1);
    chk("ovr_srq", srq, 1);
    push_ticks(48'h0001_0002_0003); push_ch01(8'h71); push_ch01(8'h72);
    read_n(11);
    chk("ovr_srq_mid", srq, 1);
    push_ticks(48'h0004_0005_0006); push_ch01(8'h73); push_ch01(8'h74);
    read_n(11);
    chk("ovr_srq_end", srq, 0);

    // nrx_samps=0 clamps to 8 sets; single channel 3, enable latched at buffer start.
    do_reset();
    nrx_samps = 10'd0; rx_en = 4'b1000; ticks = 48'hAAAA_BBBB_CCCC;
    for (int k = 0; k < 8; k++) begin
      send_set(8'h10 + 8'(k));
      rx_en = 4'b1111;
      ticks = 48'h5555_5555_5555;
      busy_len(2);
      repeat (3) tick();
      if (k == 6) chk("ns_clamp_pre", buf_ctr, 0);
    end
    chk("ns_clamp_bufctr", buf_ctr, 1);
    chk("ns_clamp_srq", srq, 1);
    push_ticks(48'hAAAA_BBBB_CCCC);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({8'h10 + 8'(k), 8'h30});
      exp_q.push_back({8'h10 + 8'(k), 8'h31});
    end
    read_n(19);

    // No channels enabled: rx_avail ignored.
    do_reset();
    rx_en = 4'b0000; nrx_samps = 10'd2;
    send_set(8'h81);
    chk("en0_busy", busy, 0);
    repeat (4) tick();
    send_set(8'h82);
    repeat (4) tick();
    chk("en0_srq", srq, 0);
    chk("en0_bufctr", buf_ctr, 0);

    // Reset in the middle of a read and a serialise.
    do_reset();
    rx_en = 4'b0011; nrx_samps = 10'd2;
    fill2(48'hCAFE_0001_0002, 8'h51, 8'h52);
    chk("mid_bufctr", buf_ctr, 1);
    push_ticks(48'hCAFE_0001_0002);
    exp_q.push_back(16'h5100);
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    rd_en = 1'b1; repeat (4) tick(); rd_en = 1'b0;
    tick();
    send_set(8'h53);
    chk("pre_rst_busy", busy, 1);
    reset_A = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);   chk("mid_rst_srq", srq, 0);
    chk("mid_rst_dout", dout, 0);   chk("mid_rst_dvalid", dout_valid, 0);
    chk("mid_rst_bufctr", buf_ctr, 0); chk("mid_rst_ovfl", ovfl, 0);
    exp_q.delete();
    tick(); tick();
    reset_A = 1'b0;
    tick();
    fill2(48'h0BAD_F00D_0003, 8'h61, 8'h62);
    chk("post_rst_bufctr", buf_ctr, 1);
    push_ticks(48'h0BAD_F00D_0003); push_ch01(8'h61); push_ch01(8'h62);
    read_n(11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
